// File: rtl/rect_overlay.sv
// Multi-rectangle overlay for the VGA pixel path.
// Holds NUM_RECT runtime-programmable rectangles. Each one has corners, a colour, and
// enable/blink/outline control bits. Every scanned pixel is tested against all of them,
// and the lowest-index visible hit wins.
//
// Ports:
//   clk, reset        pixel clock, asynchronous active-high reset
//   x, y, video_on    current pixel coordinate and visible-area flag
//   frame_tick        one-cycle pulse per frame; drives the blink counter
//   wr_en, wr_addr    register write strobe and address {rect index, field[2:0]}
//   wr_data           LSB-aligned write data
//   hit, hit_id, rgb  registered overlay result, 2 cycles after x/y/video_on
module rect_overlay #(
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned NUM_RECT     = 4,
  parameter int unsigned COLOR_W      = 12,
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [COORD_W-1:0]                            x,
  input  logic [COORD_W-1:0]                            y,
  input  logic                                          video_on,
  input  logic                                          frame_tick,
  input  logic                                          wr_en,
  input  logic [$clog2(NUM_RECT)+2:0]                   wr_addr,
  input  logic [DATA_W-1:0]                             wr_data,
  output logic                                          hit,
  output logic [(NUM_RECT > 1 ? $clog2(NUM_RECT) : 1)-1:0] hit_id,
  output logic [COLOR_W-1:0]                            rgb
);

  localparam int unsigned AddrW = $clog2(NUM_RECT) + 3;
  localparam int unsigned IdW   = (NUM_RECT > 1) ? $clog2(NUM_RECT) : 1;
  localparam int unsigned CntW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Write address decode. The rect index is one bit wider than needed, so that
  // NUM_RECT == 1 still gives a legal slice. Out-of-range indices are then rejected.
  logic [AddrW-3:0] wr_rect;
  logic [2:0]       wr_field;
  assign wr_rect  = (AddrW-2)'(wr_addr >> 3);
  assign wr_field = wr_addr[2:0];

  logic [COORD_W-1:0] x1_q    [NUM_RECT];
  logic [COORD_W-1:0] x2_q    [NUM_RECT];
  logic [COORD_W-1:0] y1_q    [NUM_RECT];
  logic [COORD_W-1:0] y2_q    [NUM_RECT];
  logic [COLOR_W-1:0] color_q [NUM_RECT];
  logic [2:0]         ctrl_q  [NUM_RECT];  // {outline, blink, enable}

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_RECT; i++) begin
        x1_q[i]    <= '0;
        x2_q[i]    <= '0;
        y1_q[i]    <= '0;
        y2_q[i]    <= '0;
        color_q[i] <= '0;
        ctrl_q[i]  <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_RECT; i++) begin
        if (32'(wr_rect) == i) begin
          case (wr_field)
            3'd0:    x1_q[i]    <= wr_data[COORD_W-1:0];
            3'd1:    x2_q[i]    <= wr_data[COORD_W-1:0];
            3'd2:    y1_q[i]    <= wr_data[COORD_W-1:0];
            3'd3:    y2_q[i]    <= wr_data[COORD_W-1:0];
            3'd4:    color_q[i] <= wr_data[COLOR_W-1:0];
            3'd5:    ctrl_q[i]  <= wr_data[2:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Blink counter: the phase flips once every BLINK_FRAMES frame ticks. It starts visible.
  logic [CntW-1:0] blink_cnt_q;
  logic            blink_phase_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == CntW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: per-rectangle hit vector. An inverted rectangle (x1 > x2 or y1 > y2) fails
  // the range test by itself, so it needs no separate check.
  logic [NUM_RECT-1:0] hit_vec_d, hit_vec_q;
  logic                von_q;

  always_comb begin
    hit_vec_d = '0;
    for (int unsigned i = 0; i < NUM_RECT; i++) begin
      hit_vec_d[i] = ctrl_q[i][0] && (!ctrl_q[i][1] || blink_phase_q) &&
                     (x >= x1_q[i]) && (x <= x2_q[i]) &&
                     (y >= y1_q[i]) && (y <= y2_q[i]) &&
                     (!ctrl_q[i][2] || (x == x1_q[i]) || (x == x2_q[i]) ||
                      (y == y1_q[i]) || (y == y2_q[i]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_vec_q <= '0;
      von_q     <= 1'b0;
    end else begin
      hit_vec_q <= hit_vec_d;
      von_q     <= video_on;
    end
  end

  // Stage 2: lowest-index priority select. The colour is read live here, which means
  // a colour write reaches a pixel that is already in stage 1.
  logic               hit_d, hit_q;
  logic [IdW-1:0]     hit_id_d, hit_id_q;
  logic [COLOR_W-1:0] rgb_d, rgb_q;

  always_comb begin
    hit_d    = 1'b0;
    hit_id_d = '0;
    rgb_d    = '0;
    for (int unsigned i = 0; i < NUM_RECT; i++) begin
      if (von_q && hit_vec_q[i] && !hit_d) begin
        hit_d    = 1'b1;
        hit_id_d = IdW'(i);
        rgb_d    = color_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q    <= 1'b0;
      hit_id_q <= '0;
      rgb_q    <= '0;
    end else begin
      hit_q    <= hit_d;
      hit_id_q <= hit_id_d;
      rgb_q    <= rgb_d;
    end
  end

  assign hit    = hit_q;
  assign hit_id = hit_id_q;
  assign rgb    = rgb_q;

endmodule

// File: tb/tb_rect_overlay.sv
module tb_rect_overlay;

  localparam int NR = 3;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0, y = '0;
  logic        video_on = 1'b0, frame_tick = 1'b0, wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        hit;
  logic [1:0]  hit_id;
  logic [11:0] rgb;

  rect_overlay #(
    .COORD_W(10), .NUM_RECT(NR), .COLOR_W(12), .DATA_W(12), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on), .frame_tick(frame_tick),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hit(hit), .hit_id(hit_id), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: register file, blink state, and the pixel in flight.
  int m_x1[NR], m_x2[NR], m_y1[NR], m_y2[NR], m_col[NR], m_ctl[NR];
  int m_cnt = 0;
  bit m_phase = 1'b1;
  int p_win = -1;   // winner for the pixel that was sampled at the last edge
  bit p_von = 1'b0;
  logic        e_hit = 1'b0;
  logic [1:0]  e_id = '0;
  logic [11:0] e_rgb = '0;

  function automatic int winner(int px, int py);
    for (int i = 0; i < NR; i++) begin
      bit vis = (m_ctl[i] & 1) != 0 && ((m_ctl[i] & 2) == 0 || m_phase);
      bit ins = px >= m_x1[i] && px <= m_x2[i] && py >= m_y1[i] && py <= m_y2[i];
      bit edg = px == m_x1[i] || px == m_x2[i] || py == m_y1[i] || py == m_y2[i];
      if (vis && ins && ((m_ctl[i] & 4) == 0 || edg)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_x1[i] = 0; m_x2[i] = 0; m_y1[i] = 0; m_y2[i] = 0; m_col[i] = 0; m_ctl[i] = 0;
    end
    m_cnt = 0; m_phase = 1'b1; p_win = -1; p_von = 1'b0;
    e_hit = 1'b0; e_id = '0; e_rgb = '0;
  endtask

  // One rising edge. Inputs are still at their pre-edge values when this runs.
  task automatic model_edge();
    int idx, fld;
    bit h;
    h = p_von && p_win >= 0;
    e_hit = h;
    e_id  = h ? 2'(p_win) : 2'd0;
    e_rgb = h ? 12'(m_col[p_win]) : 12'd0;
    p_win = winner(int'(x), int'(y));
    p_von = video_on;
    if (wr_en) begin
      idx = int'(wr_addr) >> 3;
      fld = int'(wr_addr) & 7;
      if (idx < NR) begin
        case (fld)
          0: m_x1[idx]  = int'(wr_data) & 1023;
          1: m_x2[idx]  = int'(wr_data) & 1023;
          2: m_y1[idx]  = int'(wr_data) & 1023;
          3: m_y2[idx]  = int'(wr_data) & 1023;
          4: m_col[idx] = int'(wr_data) & 4095;
          5: m_ctl[idx] = int'(wr_data) & 7;
          default: ;
        endcase
      end
    end
    if (frame_tick) begin
      if (m_cnt == BF - 1) begin
        m_cnt = 0;
        m_phase = !m_phase;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    n_vec++;
    if (hit !== e_hit || hit_id !== e_id || rgb !== e_rgb) begin
      n_err++;
      $display("FAIL model t=%0t got hit=%b id=%0d rgb=%h, want hit=%b id=%0d rgb=%h",
               $time, hit, hit_id, rgb, e_hit, e_id, e_rgb);
    end
  end

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic lit(string name, logic eh, logic [1:0] eid, logic [11:0] erg);
    #1;
    n_vec++;
    if (hit !== eh || hit_id !== eid || rgb !== erg) begin
      n_err++;
      $display("FAIL %s got hit=%b id=%0d rgb=%h, want hit=%b id=%0d rgb=%h",
               name, hit, hit_id, rgb, eh, eid, erg);
    end
  endtask

  task automatic wr(int idx, int fld, int d);
    wr_en = 1'b1;
    wr_addr = 5'(idx * 8 + fld);
    wr_data = 12'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic set_rect(int idx, int ax1, int ax2, int ay1, int ay2, int col, int ctl);
    wr(idx, 0, ax1); wr(idx, 1, ax2); wr(idx, 2, ay1); wr(idx, 3, ay2);
    wr(idx, 4, col); wr(idx, 5, ctl);
  endtask

  task automatic probe(string name, int px, int py, bit pv,
                       logic eh, logic [1:0] eid, logic [11:0] erg);
    x = 10'(px); y = 10'(py); video_on = pv;
    step();
    video_on = 1'b0;
    step();
    lit(name, eh, eid, erg);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    lit("reset_held", 1'b0, 2'd0, 12'h000);
    reset = 1'b0;

    // Nothing is enabled, so the whole line must stay dark.
    y = 10'd100; video_on = 1'b1;
    for (int i = 0; i < 640; i++) begin
      x = 10'(i);
      step();
    end
    video_on = 1'b0;

    set_rect(0, 320, 325, 100, 105, 'hF00, 1);
    probe("r0_tl", 320, 100, 1, 1'b1, 2'd0, 12'hF00);
    probe("r0_br", 325, 105, 1, 1'b1, 2'd0, 12'hF00);
    probe("r0_right", 326, 105, 1, 1'b0, 2'd0, 12'h000);
    probe("r0_left", 319, 100, 1, 1'b0, 2'd0, 12'h000);

    set_rect(1, 0, 639, 0, 479, 'h0F0, 1);
    probe("prio_r0", 322, 102, 1, 1'b1, 2'd0, 12'hF00);
    probe("prio_r1", 10, 10, 1, 1'b1, 2'd1, 12'h0F0);
    wr(0, 5, 0);
    probe("r0_off", 322, 102, 1, 1'b1, 2'd1, 12'h0F0);

    wr(1, 5, 0);
    wr(0, 5, 5);
    probe("outline_edge", 320, 102, 1, 1'b1, 2'd0, 12'hF00);
    probe("outline_mid", 322, 102, 1, 1'b0, 2'd0, 12'h000);

    set_rect(2, 40, 50, 40, 50, 'h00F, 3);
    probe("blink_t0", 45, 45, 1, 1'b1, 2'd2, 12'h00F);
    tick(); probe("blink_t1", 45, 45, 1, 1'b1, 2'd2, 12'h00F);
    tick(); probe("blink_t2", 45, 45, 1, 1'b0, 2'd0, 12'h000);
    tick(); probe("blink_t3", 45, 45, 1, 1'b0, 2'd0, 12'h000);
    tick(); probe("blink_t4", 45, 45, 1, 1'b1, 2'd2, 12'h00F);
    probe("video_off", 45, 45, 0, 1'b0, 2'd0, 12'h000);

    set_rect(1, 10, 5, 0, 479, 'hABC, 1);
    probe("inv_a", 7, 10, 1, 1'b0, 2'd0, 12'h000);
    probe("inv_b", 10, 10, 1, 1'b0, 2'd0, 12'h000);
    probe("inv_c", 5, 10, 1, 1'b0, 2'd0, 12'h000);

    wr(3, 4, 'hFFF);
    probe("bad_index", 45, 45, 1, 1'b1, 2'd2, 12'h00F);
    wr(2, 6, 0);
    probe("field6", 45, 45, 1, 1'b1, 2'd2, 12'h00F);

    // Hide the blinking rect. A reset must then bring the blink phase back to visible.
    tick(); tick();
    probe("blink_hidden", 45, 45, 1, 1'b0, 2'd0, 12'h000);
    x = 10'd320; y = 10'd100; video_on = 1'b1;
    step(); step();
    lit("pre_reset", 1'b1, 2'd0, 12'hF00);
    #1 reset = 1'b1;
    model_reset();
    lit("rst_async", 1'b0, 2'd0, 12'h000);
    step(); step();
    reset = 1'b0;
    video_on = 1'b0;
    set_rect(2, 40, 50, 40, 50, 'h00F, 3);
    probe("blink_restart", 45, 45, 1, 1'b1, 2'd2, 12'h00F);

    // Random traffic in a small window so that rectangles overlap and hit often.
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 5'($urandom_range(0, 31));
      if ((wr_addr & 5'd7) == 5'd5) wr_data = 12'($urandom_range(0, 7));
      else if ((wr_addr & 5'd7) == 5'd4) wr_data = 12'($urandom);
      else wr_data = 12'($urandom_range(0, 63));
      x = ($urandom_range(0, 15) == 0) ? 10'($urandom) : 10'($urandom_range(0, 63));
      y = 10'($urandom_range(0, 63));
      video_on = ($urandom_range(0, 4) != 0);
      frame_tick = ($urandom_range(0, 7) == 0);
      step();
    end
    wr_en = 1'b0; frame_tick = 1'b0; video_on = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
